// File: rtl/uart_host_pkg.sv
// uart_host_pkg: shared types for the UART host bridge.
// Holds the TX/RX engine state encodings and the default TX buffer depth.
package uart_host_pkg;

  // Default number of TX FIFO entries (power of two, 2..16).
  localparam int TX_DEPTH_DEFAULT = 4;

  // Host byte width on both directions.
  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    TX_IDLE    = 2'd0,
    TX_START   = 2'd1,
    TX_RELEASE = 2'd2
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE = 2'd0,
    RX_WAIT = 2'd1,
    RX_ACK  = 2'd2
  } rx_state_t;

endpackage

// File: rtl/uart_host_fifo.sv
// uart_host_fifo: small TX byte FIFO with wrapping pointers and an occupancy
// counter. Used by uart_host_bridge only when UART_HOST_TX_FIFO_EN is defined.
// A push while full is dropped even if a pop happens in the same cycle.
module uart_host_fifo
  import uart_host_pkg::*;
#(
  parameter int DEPTH = TX_DEPTH_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_push,
  input  logic [BYTE_W-1:0] i_data,
  input  logic              i_pop,
  output logic [BYTE_W-1:0] o_head,
  output logic              o_full,
  output logic              o_empty
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  logic [BYTE_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  logic w_push_ok;
  logic w_pop_ok;

  assign o_full    = (r_count == FULL_COUNT);
  assign o_empty   = (r_count == '0);
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;
  assign o_head    = r_mem[r_rd_ptr];

  // Storage write; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_host_bridge.sv
// uart_host_bridge: connects a simple host byte interface to a UART core.
// TX: host bytes are buffered and handed to the UART one at a time through a
// start_tx / tx_done handshake. RX: a received byte is captured into a holding
// register and acknowledged with rx_clear; a new byte is left pending in the
// UART until the host has read the previous one.
// Build option: define UART_HOST_TX_FIFO_EN to buffer TX bytes in a TX_DEPTH
// entry FIFO (uart_host_fifo); otherwise a single holding register is used and
// TX_DEPTH has no effect.
module uart_host_bridge
  import uart_host_pkg::*;
#(
  parameter int TX_DEPTH = TX_DEPTH_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  // Host TX side
  input  logic              wr_en,
  input  logic [BYTE_W-1:0] wr_data,
  output logic              tx_full,
  output logic              tx_busy,
  // Host RX side
  input  logic              rd_en,
  output logic [BYTE_W-1:0] rd_data,
  output logic              rx_valid,
  // UART TX side
  output logic              start_tx,
  output logic [BYTE_W-1:0] tx_value,
  input  logic              tx_done,
  // UART RX side
  input  logic              rx_available,
  input  logic [BYTE_W-1:0] rx_value,
  output logic              rx_clear
);

  // Reject unsupported depths at elaboration time.
  if (TX_DEPTH < 2 || TX_DEPTH > 16 || (TX_DEPTH & (TX_DEPTH - 1)) != 0) begin : g_bad_tx_depth
    $error("uart_host_bridge: TX_DEPTH must be a power of two in 2..16");
  end

  // ---------------------------------------------------------------------------
  // TX buffer
  // ---------------------------------------------------------------------------
  logic              w_buf_push;
  logic              w_buf_pop;
  logic              w_buf_full;
  logic              w_buf_empty;
  logic [BYTE_W-1:0] w_buf_head;

  // A push while full is dropped regardless of a same-cycle pop.
  assign w_buf_push = wr_en && !w_buf_full;

`ifdef UART_HOST_TX_FIFO_EN
  uart_host_fifo #(
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_buf_push),
    .i_data  (wr_data),
    .i_pop   (w_buf_pop),
    .o_head  (w_buf_head),
    .o_full  (w_buf_full),
    .o_empty (w_buf_empty)
  );
`else
  logic              r_hold_valid;
  logic [BYTE_W-1:0] r_hold_data;

  // Single-entry holding register; push and pop never coincide because a push
  // needs it empty and a pop needs it occupied.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold_valid <= 1'b0;
      r_hold_data  <= '0;
    end else if (w_buf_push) begin
      r_hold_valid <= 1'b1;
      r_hold_data  <= wr_data;
    end else if (w_buf_pop) begin
      r_hold_valid <= 1'b0;
    end
  end

  assign w_buf_full  = r_hold_valid;
  assign w_buf_empty = !r_hold_valid;
  assign w_buf_head  = r_hold_data;
`endif

  // ---------------------------------------------------------------------------
  // TX engine
  // ---------------------------------------------------------------------------
  tx_state_t         r_tx_state;
  tx_state_t         w_tx_state_next;
  logic              w_tx_load;
  logic [BYTE_W-1:0] r_tx_value;

  // TX state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_state <= TX_IDLE;
    end else begin
      r_tx_state <= w_tx_state_next;
    end
  end

  // TX next state: take a byte when idle, wait for done, then wait for done
  // to fall so every transfer is separated by at least one low start_tx cycle.
  always_comb begin
    w_tx_state_next = r_tx_state;
    w_buf_pop       = 1'b0;
    w_tx_load       = 1'b0;
    case (r_tx_state)
      TX_IDLE: begin
        if (!w_buf_empty) begin
          w_buf_pop       = 1'b1;
          w_tx_load       = 1'b1;
          w_tx_state_next = TX_START;
        end
      end
      TX_START: begin
        if (tx_done) begin
          w_tx_state_next = TX_RELEASE;
        end
      end
      TX_RELEASE: begin
        if (!tx_done) begin
          w_tx_state_next = TX_IDLE;
        end
      end
      default: w_tx_state_next = TX_IDLE;
    endcase
  end

  // Transmit byte register; stays stable for the whole request.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_value <= '0;
    end else if (w_tx_load) begin
      r_tx_value <= w_buf_head;
    end
  end

  assign start_tx = (r_tx_state == TX_START);
  assign tx_value = r_tx_value;
  assign tx_full  = w_buf_full;
  assign tx_busy  = !w_buf_empty || (r_tx_state != TX_IDLE);

  // ---------------------------------------------------------------------------
  // RX engine
  // ---------------------------------------------------------------------------
  rx_state_t         r_rx_state;
  rx_state_t         w_rx_state_next;
  logic              w_rx_capture;
  logic [BYTE_W-1:0] r_rd_data;
  logic              r_rx_valid;

  // RX state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_state <= RX_IDLE;
    end else begin
      r_rx_state <= w_rx_state_next;
    end
  end

  // RX next state: only accept a byte when the holding register is free, skip
  // the first rx_available cycle (data not yet valid), then acknowledge.
  always_comb begin
    w_rx_state_next = r_rx_state;
    w_rx_capture    = 1'b0;
    case (r_rx_state)
      RX_IDLE: begin
        if (rx_available && !r_rx_valid) begin
          w_rx_state_next = RX_WAIT;
        end
      end
      RX_WAIT: begin
        w_rx_capture    = 1'b1;
        w_rx_state_next = RX_ACK;
      end
      RX_ACK: begin
        if (!rx_available) begin
          w_rx_state_next = RX_IDLE;
        end
      end
      default: w_rx_state_next = RX_IDLE;
    endcase
  end

  // Holding register and its valid flag; a read clears only the flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_data  <= '0;
      r_rx_valid <= 1'b0;
    end else if (w_rx_capture) begin
      r_rd_data  <= rx_value;
      r_rx_valid <= 1'b1;
    end else if (rd_en && r_rx_valid) begin
      r_rx_valid <= 1'b0;
    end
  end

  assign rd_data  = r_rd_data;
  assign rx_valid = r_rx_valid;
  assign rx_clear = (r_rx_state == RX_ACK);

endmodule

// File: tb/tb_uart_host_bridge.sv
// tb_uart_host_bridge: scoreboard bench for uart_host_bridge.
// Stimulus pushes expected bytes into queues; a monitor compares them against
// tx_value at each start_tx rise and rd_data at each rx_valid rise.
// Buffer capacity follows UART_HOST_TX_FIFO_EN (TX_DEPTH entries or one).
module tb_uart_host_bridge;
  import uart_host_pkg::*;

  localparam int TX_DEPTH = TX_DEPTH_DEFAULT;
`ifdef UART_HOST_TX_FIFO_EN
  localparam int CAP = TX_DEPTH;
`else
  localparam int CAP = 1;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       tx_full;
  logic       tx_busy;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       rx_valid;
  logic       start_tx;
  logic [7:0] tx_value;
  logic       tx_done;
  logic       rx_available;
  logic [7:0] rx_value;
  logic       rx_clear;

  always #5 clk = ~clk;

  uart_host_bridge #(.TX_DEPTH(TX_DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .tx_full      (tx_full),
    .tx_busy      (tx_busy),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .rx_valid     (rx_valid),
    .start_tx     (start_tx),
    .tx_value     (tx_value),
    .tx_done      (tx_done),
    .rx_available (rx_available),
    .rx_value     (rx_value),
    .rx_clear     (rx_clear)
  );

  int checks = 0;
  int errors = 0;

  // Scoreboard queues: written only by stimulus, read via monitor-owned indices.
  logic [7:0] exp_tx[$];
  logic [7:0] exp_rx[$];
  int tx_rd_idx = 0;
  int rx_rd_idx = 0;
  int accepted  = 0;   // bytes the reference buffer accepted
  int started   = 0;   // transfers seen starting (bytes left the buffer)

  logic stall    = 1'b0;
  int   done_lat = 20;
  int   done_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // UART transmitter model: done after done_lat cycles of start_tx, held until start_tx drops.
  initial begin
    tx_done = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (tx_done) begin
        if (!start_tx) tx_done = 1'b0;
      end else if (start_tx && !stall) begin
        done_cnt++;
        if (done_cnt >= done_lat) begin
          tx_done  = 1'b1;
          done_cnt = 0;
        end
      end else begin
        done_cnt = 0;
      end
    end
  end

  // Monitor.
  logic       prev_start = 1'b0;
  logic       prev_rx_valid = 1'b0;
  logic       prev_rx_clear = 1'b0;
  logic [7:0] held_tx = 8'h00;
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        tx_rd_idx = exp_tx.size();
        started   = accepted;
      end else begin
        if (start_tx && !prev_start) begin
          started++;
          chk("tx_start_expected", 32'(tx_rd_idx < exp_tx.size()), 32'd1);
          if (tx_rd_idx < exp_tx.size()) begin
            chk("tx_value", 32'(tx_value), 32'(exp_tx[tx_rd_idx]));
            tx_rd_idx++;
          end
          held_tx = tx_value;
        end else if (start_tx) begin
          chk("tx_value_stable", 32'(tx_value), 32'(held_tx));
        end
        if (rx_valid && !prev_rx_valid) begin
          chk("rx_capture_expected", 32'(rx_rd_idx < exp_rx.size()), 32'd1);
          if (rx_rd_idx < exp_rx.size()) begin
            chk("rd_data", 32'(rd_data), 32'(exp_rx[rx_rd_idx]));
            rx_rd_idx++;
          end
        end
        if (rx_clear && !prev_rx_clear)
          chk("rx_clear_with_capture", 32'({prev_rx_valid, rx_valid}), 32'd1);
        if (!rx_clear && prev_rx_clear)
          chk("rx_clear_held_while_avail", 32'(rx_available), 32'd0);
      end
      prev_start    = start_tx;
      prev_rx_valid = rx_valid;
      prev_rx_clear = rx_clear;
    end
  end

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic host_push(input logic [7:0] b);
    chk("tx_full", 32'(tx_full), 32'((accepted - started) >= CAP));
    if ((accepted - started) > 0) chk("tx_busy_occupied", 32'(tx_busy), 32'd1);
    wr_en   = 1'b1;
    wr_data = b;
    if ((accepted - started) < CAP) begin
      exp_tx.push_back(b);
      accepted++;
    end
    tick();
    wr_en = 1'b0;
  endtask

  task automatic host_push_wait(input logic [7:0] b);
    int n = 0;
    while ((accepted - started) >= CAP && n < 500) begin tick(); n++; end
    chk("push_wait_in_time", 32'(n < 500), 32'd1);
    host_push(b);
  endtask

  task automatic wait_start();
    int n = 0;
    while (!start_tx && n < 50) begin tick(); n++; end
    chk("start_tx_seen", 32'(start_tx), 32'd1);
  endtask

  task automatic drain();
    int n = 0;
    while ((accepted != started || tx_busy) && n < 3000) begin tick(); n++; end
    chk("tx_drained", 32'({accepted == started, tx_busy}), 32'h2);
  endtask

  task automatic rx_raise(input logic [7:0] b);
    exp_rx.push_back(b);
    rx_available = 1'b1;
    rx_value     = 8'($urandom);
    tick();
    rx_value = b;
  endtask

  task automatic rx_finish();
    int n = 0;
    while (!rx_clear && n < 40) begin tick(); n++; end
    chk("rx_clear_seen", 32'(rx_clear), 32'd1);
    chk("rx_valid_set", 32'(rx_valid), 32'd1);
    rx_available = 1'b0;
    tick(); tick();
    chk("rx_clear_dropped", 32'(rx_clear), 32'd0);
  endtask

  task automatic host_read(input logic [7:0] exp);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("rx_valid_cleared", 32'(rx_valid), 32'd0);
    chk("rd_data_held", 32'(rd_data), 32'(exp));
  endtask

  logic [7:0] b_a;
  logic [7:0] b_b;

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00; rd_en = 1'b0;
    rx_available = 1'b0; rx_value = 8'h00;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_start_tx", 32'(start_tx), 32'd0);
    chk("rst_tx_value", 32'(tx_value), 32'd0);
    chk("rst_rx_clear", 32'(rx_clear), 32'd0);
    chk("rst_rd_data",  32'(rd_data),  32'd0);
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_tx_full",  32'(tx_full),  32'd0);
    chk("rst_tx_busy",  32'(tx_busy),  32'd0);

    // Two bytes in order with a 20-cycle UART.
    host_push_wait(8'h55);
    host_push_wait(8'hA3);
    drain();

    // Engine stalled mid-transfer, then five back-to-back pushes.
    stall = 1'b1;
    host_push_wait(8'hE0);
    wait_start();
    for (int i = 0; i < 5; i++) host_push(8'($urandom));
    chk("tx_full_after_burst", 32'(tx_full), 32'((accepted - started) >= CAP));
    stall = 1'b0;
    done_lat = 2;
    drain();

    // Random traffic with varying UART latency.
    for (int i = 0; i < 200; i++) begin
      done_lat = $urandom_range(1, 4);
      if ($urandom_range(0, 1) == 1) host_push(8'($urandom));
      else tick();
    end
    drain();

    // Reset while a transfer is in progress and bytes are queued.
    stall = 1'b1;
    host_push_wait(8'h11);
    wait_start();
    for (int i = 0; i < 3; i++) host_push(8'($urandom));
    rst = 1'b1;
    tick();
    chk("midrst_start_tx", 32'(start_tx), 32'd0);
    chk("midrst_tx_busy",  32'(tx_busy),  32'd0);
    chk("midrst_tx_full",  32'(tx_full),  32'd0);
    chk("midrst_tx_value", 32'(tx_value), 32'd0);
    rst = 1'b0;
    stall = 1'b0;
    tick();
    host_push_wait(8'h7E);
    drain();

    // Single received byte.
    rx_raise(8'h3C);
    rx_finish();
    host_read(8'h3C);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("idle_read_ignored", 32'({rx_valid, rd_data}), 32'h03C);

    // Second byte arrives before the first is read: must stay unacknowledged.
    b_a = 8'($urandom);
    b_b = 8'($urandom);
    rx_raise(b_a);
    rx_finish();
    rx_raise(b_b);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("no_ack_while_full", 32'({rx_clear, rd_data}), 32'(b_a));
    end
    host_read(b_a);
    rx_finish();
    host_read(b_b);

    // Random receive traffic.
    for (int i = 0; i < 20; i++) begin
      b_a = 8'($urandom);
      rx_raise(b_a);
      rx_finish();
      repeat ($urandom_range(0, 3)) tick();
      host_read(b_a);
    end

    chk("tx_all_sent", 32'(tx_rd_idx), 32'(exp_tx.size()));
    chk("rx_all_captured", 32'(rx_rd_idx), 32'(exp_rx.size()));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard stop in case something never terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
